pwm_audio_dac: RTL



---
 rtl/pwm_audio_dac_pkg.sv | 13 +
 rtl/pwm_audio_dac_clk_en_div.sv | 28 ++
 rtl/pwm_audio_dac.sv | 105 ++++++++++
 3 files changed

// File: rtl/pwm_audio_dac_pkg.sv
// Shared constants for the PWM audio output stage and its prescaler.
package pwm_audio_dac_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int VOL_W_DEF  = 3;
    localparam int CNT_MAX    = (1 << DATA_W_DEF) - 1;

    // Terminal count of a PWM counter of the given width.
    function automatic int cnt_max(input int width);
        return (1 << width) - 1;
    endfunction

endpackage

// File: rtl/pwm_audio_dac_clk_en_div.sv
// Clock-enable divider (clk_en_div): one-cycle tick every PRESCALE clocks, held at phase 0 while hold=1.
module pwm_audio_dac_clk_en_div #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic hold,
    output logic tick
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] presc;

    assign tick = !hold && (presc == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
        end else if (hold || tick) begin
            presc <= '0;
        end else begin
            presc <= presc + PW'(1);
        end
    end

endmodule

// File: rtl/pwm_audio_dac.sv
// PWM audio output: one-entry skid buffer feeding one sample per PWM period, with attenuation and underrun flag.
module pwm_audio_dac
    import pwm_audio_dac_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int PRESCALE = 1,
    parameter int VOL_W    = VOL_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic              enable,
    input  logic [VOL_W-1:0]  vol,
    input  logic              clr_underrun,
    output logic              pwm_out,
    output logic              amp_en,
    output logic              period_start,
    output logic              underrun
);

    localparam logic [DATA_W-1:0] CNT_TOP = DATA_W'(cnt_max(DATA_W));

    function automatic logic [DATA_W-1:0] attenuate(input logic [DATA_W-1:0] s,
                                                    input logic [VOL_W-1:0]  v);
        return s >> v;
    endfunction

    logic [DATA_W-1:0] sample_buf;
    logic              buf_full;
    logic [DATA_W-1:0] duty;
    logic [DATA_W-1:0] cnt;
    logic              tick;
    logic              boundary;
    logic              accept;

    assign s_ready  = !buf_full;
    assign accept   = s_valid && !buf_full;
    assign boundary = tick && (cnt == CNT_TOP);

    pwm_audio_dac_clk_en_div #(
        .PRESCALE(PRESCALE)
    ) u_div (
        .clk (clk),
        .rst (rst),
        .hold(!enable),
        .tick(tick)
    );

    // Buffered sample carries no reset; buf_full alone says whether it is meaningful.
    always_ff @(posedge clk) begin
        if (accept) begin
            sample_buf <= s_data;
        end
    end

    // Accept and load are mutually exclusive: accept needs an empty buffer, load a full one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_full <= 1'b0;
            duty     <= '0;
        end else if (accept) begin
            buf_full <= 1'b1;
        end else if (boundary && buf_full) begin
            duty     <= attenuate(sample_buf, vol);
            buf_full <= 1'b0;
        end
    end

    // Idle counter parks at the top so the first tick after enable is a boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= CNT_TOP;
        end else if (!enable) begin
            cnt <= CNT_TOP;
        end else if (tick) begin
            cnt <= cnt + DATA_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_out      <= 1'b0;
            amp_en       <= 1'b0;
            period_start <= 1'b0;
        end else begin
            pwm_out      <= enable && (cnt < duty);
            amp_en       <= enable;
            period_start <= boundary;
        end
    end

    // A starving boundary takes priority over a clear in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            underrun <= 1'b0;
        end else if (boundary && !buf_full) begin
            underrun <= 1'b1;
        end else if (clr_underrun) begin
            underrun <= 1'b0;
        end
    end

endmodule
